seg7_scan_driver: RTL and testbench

Downstream consumer of the chained BCD digit counters: takes the packed digit vector of a `NUM_DIGITS`-digit counter chain and time-multiplexes it onto a common-segment seven-segment display. It snapshots all digits once per frame (no tearing between digits), decodes one digit at a time to segment patterns and walks a one-hot anode select at a programmable refresh rate. It sits between the counter chain and the board pins.

---
 rtl/seg7_pkg.sv | 40 ++++
 rtl/seg7_decoder.sv | 16 +
 rtl/seg7_scan_driver.sv | 137 +++++++++++++
 tb/tb_seg7_scan_driver.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants and BCD-to-segment decode for the seven-segment scan driver.
// Latency: none (constants and a pure combinational function).
// Backpressure: not applicable.
// Segment bit order is bit 0 = a ... bit 6 = g, active-high.
package seg7_pkg;

    localparam int BCD_W = 4;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Non-decimal codes (10..15) light nothing rather than a hex glyph.
    function automatic logic [6:0] seg7_decode(input logic [BCD_W-1:0] bcd);
        logic [6:0] pat;
        case (bcd)
            4'd0:    pat = SEG_0;
            4'd1:    pat = SEG_1;
            4'd2:    pat = SEG_2;
            4'd3:    pat = SEG_3;
            4'd4:    pat = SEG_4;
            4'd5:    pat = SEG_5;
            4'd6:    pat = SEG_6;
            4'd7:    pat = SEG_7;
            4'd8:    pat = SEG_8;
            4'd9:    pat = SEG_9;
            default: pat = SEG_BLANK;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD digit to active-high seven-segment pattern.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows input continuously.
module seg7_decoder
    import seg7_pkg::*;
(
    input  logic [BCD_W-1:0] bcd,
    output logic [6:0]       seg
);

    // Table lookup shared with any other user of the package.
    always_comb begin
        seg = seg7_decode(bcd);
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexes a snapshotted packed BCD vector onto a common-segment 7-seg display.
// Latency: 1 cycle from (idx, snapshot) to pins; all outputs registered.
// Backpressure: en low freezes scan state and blanks pins. Optional macro SEG7_LEADING_ZERO_BLANK_EN.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int ACTIVE_LOW  = 1
)
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic [BCD_W*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]       dp_in,
    output logic [6:0]                  seg,
    output logic                        dp,
    output logic [NUM_DIGITS-1:0]       an,
    output logic                        frame_start
);

    localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    // Inversion mask applied only at the pin registers.
    localparam logic POL = (ACTIVE_LOW != 0);
    localparam logic [NUM_DIGITS-1:0] AN_ONE = NUM_DIGITS'(1);

    logic [CNT_W-1:0]              cnt;
    logic [IDX_W-1:0]              idx;
    logic [BCD_W*NUM_DIGITS-1:0]   snap_digits;
    logic [NUM_DIGITS-1:0]         snap_dp;
    logic                          load_pending;

    logic                          slot_end;
    logic                          frame_wrap;
    logic                          snap_load;
    logic [BCD_W*NUM_DIGITS-1:0]   src_digits;
    logic [NUM_DIGITS-1:0]         src_dp;
    logic [BCD_W-1:0]              cur_bcd;
    logic                          cur_dp;
    logic                          cur_blank;
    logic [6:0]                    dec_seg;
    logic [6:0]                    seg_hi;
    logic [NUM_DIGITS-1:0]         an_hi;

    assign slot_end   = en && (cnt == CNT_LAST);
    assign frame_wrap = slot_end && (idx == IDX_LAST);
    assign snap_load  = en && (load_pending || frame_wrap);

    // The first enabled cycle after reset must already display the fresh
    // inputs on the next cycle, so bypass the snapshot while a load is pending.
    assign src_digits = load_pending ? digits_in : snap_digits;
    assign src_dp     = load_pending ? dp_in     : snap_dp;

    assign cur_bcd = src_digits[idx*BCD_W +: BCD_W];
    assign cur_dp  = src_dp[idx];

    // Prescaler and digit index advance only while enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            idx <= '0;
        end else if (en) begin
            if (cnt == CNT_LAST) begin
                cnt <= '0;
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Frame snapshot: taken on the frame wrap so digits never tear mid-frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            snap_digits  <= '0;
            snap_dp      <= '0;
            load_pending <= 1'b1;
        end else if (snap_load) begin
            snap_digits  <= digits_in;
            snap_dp      <= dp_in;
            load_pending <= 1'b0;
        end
    end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] lz_mask;
    logic                  zero_above;

    // A digit is blanked when it and every more significant digit are zero;
    // digit 0 is never blanked so an all-zero value still shows "0".
    always_comb begin
        lz_mask    = '0;
        zero_above = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            zero_above = zero_above && (src_digits[k*BCD_W +: BCD_W] == '0);
            lz_mask[k] = zero_above;
        end
    end

    assign cur_blank = lz_mask[idx];
`else
    assign cur_blank = 1'b0;
`endif

    seg7_decoder u_decoder (
        .bcd (cur_bcd),
        .seg (dec_seg)
    );

    assign seg_hi = cur_blank ? SEG_BLANK : dec_seg;
    assign an_hi  = AN_ONE << idx;

    // Pin registers: anode and segment update together; polarity applied here.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg         <= {7{POL}};
            dp          <= POL;
            an          <= {NUM_DIGITS{POL}};
            frame_start <= 1'b0;
        end else if (en) begin
            seg         <= seg_hi ^ {7{POL}};
            dp          <= cur_dp ^ POL;
            an          <= an_hi ^ {NUM_DIGITS{POL}};
            frame_start <= (idx == '0) && (cnt == '0);
        end else begin
            seg         <= {7{POL}};
            dp          <= POL;
            an          <= {NUM_DIGITS{POL}};
            frame_start <= 1'b0;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver (4 digits, 4-cycle slots, active-low pins).
// Reference model counts enabled cycles since reset and derives slot/frame from arithmetic.
// Build with or without SEG7_LEADING_ZERO_BLANK_EN; expectations follow the macro.
module tb_seg7_scan_driver;

    localparam int N  = 4;
    localparam int RD = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b0;
    logic [15:0] digits_in = 16'h0000;
    logic [3:0]  dp_in = 4'b0000;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_start;

    int n_checks = 0;
    int n_pass   = 0;

    seg7_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(RD), .ACTIVE_LOW(1)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .digits_in   (digits_in),
        .dp_in       (dp_in),
        .seg         (seg),
        .dp          (dp),
        .an          (an),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int unsigned ecount;
    bit          pending;
    logic [15:0] m_snap;
    logic [3:0]  m_dp;
    logic [6:0]  exp_seg = 7'h7F;
    logic        exp_dp  = 1'b1;
    logic [3:0]  exp_an  = 4'hF;
    logic        exp_fs  = 1'b0;

    function automatic logic [6:0] ref_pattern(input logic [3:0] v);
        logic [6:0] p;
        case (v)
            4'd0: p = 7'h3F;  4'd1: p = 7'h06;  4'd2: p = 7'h5B;  4'd3: p = 7'h4F;
            4'd4: p = 7'h66;  4'd5: p = 7'h6D;  4'd6: p = 7'h7D;  4'd7: p = 7'h07;
            4'd8: p = 7'h7F;  4'd9: p = 7'h6F;
            default: p = 7'h00;
        endcase
        return p;
    endfunction

    // Expected pins for the next cycle, computed from the inputs seen at this edge.
    always @(posedge clk) begin
        int k;
        logic [6:0] pat;
        if (rst) begin
            ecount = 0; pending = 1'b1; m_snap = 16'h0; m_dp = 4'h0;
            exp_seg = 7'h7F; exp_dp = 1'b1; exp_an = 4'hF; exp_fs = 1'b0;
        end else if (en) begin
            if (pending) begin
                m_snap = digits_in; m_dp = dp_in; pending = 1'b0;
            end
            k   = (ecount / RD) % N;
            pat = ref_pattern(m_snap[4*k +: 4]);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
            if (k > 0 && (m_snap >> (4*k)) == 16'h0) pat = 7'h00;
`endif
            exp_seg = ~pat;
            exp_dp  = ~m_dp[k];
            exp_an  = ~(4'b0001 << k);
            exp_fs  = (ecount % (N*RD)) == 0;
            if ((ecount % (N*RD)) == N*RD - 1) begin
                m_snap = digits_in; m_dp = dp_in;
            end
            ecount++;
        end else begin
            exp_seg = 7'h7F; exp_dp = 1'b1; exp_an = 4'hF; exp_fs = 1'b0;
        end
    end

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; en = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (seg !== 7'h7F) $display("FAIL reset_seg got=%h want=7f", seg); else n_pass++;
        n_checks++; if (dp !== 1'b1) $display("FAIL reset_dp got=%b want=1", dp); else n_pass++;
        n_checks++; if (an !== 4'hF) $display("FAIL reset_an got=%b want=1111", an); else n_pass++;
        n_checks++; if (frame_start !== 1'b0) $display("FAIL reset_fs got=%b want=0", frame_start); else n_pass++;
    endtask

    task automatic test_scan_1234();
        int fs_count = 0;
        rst = 1'b0; en = 1'b1; digits_in = 16'h1234; dp_in = 4'b0000;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (frame_start === 1'b1) fs_count++;
            if (i == 0) begin
                n_checks++;
                if ({an, seg, frame_start} !== {4'b1110, ~7'h66, 1'b1})
                    $display("FAIL scan_first got an=%b seg=%h fs=%b want an=1110 seg=19 fs=1", an, seg, frame_start);
                else n_pass++;
            end
            if (i == 12) begin
                n_checks++;
                if ({an, seg} !== {4'b0111, ~7'h06})
                    $display("FAIL scan_digit3 got an=%b seg=%h want an=0111 seg=79", an, seg);
                else n_pass++;
            end
            n_checks++;
            if ({seg, dp, an, frame_start} !== {exp_seg, exp_dp, exp_an, exp_fs})
                $display("FAIL scan_1234 cyc=%0d got seg=%h dp=%b an=%b fs=%b want seg=%h dp=%b an=%b fs=%b",
                         i, seg, dp, an, frame_start, exp_seg, exp_dp, exp_an, exp_fs);
            else n_pass++;
        end
        n_checks++;
        if (fs_count !== 2) $display("FAIL scan_fs_count got=%0d want=2", fs_count); else n_pass++;
    endtask

    task automatic test_midframe_change();
        for (int i = 0; i < 40; i++) begin
            if (i == 6) digits_in = 16'h5678;
            @(negedge clk);
            if (i == 10) begin
                n_checks++;
                if ({an, seg} !== {4'b1011, ~7'h5B})
                    $display("FAIL midframe_old got an=%b seg=%h want an=1011 seg=24", an, seg);
                else n_pass++;
            end
            if (i == 16) begin
                n_checks++;
                if ({an, seg} !== {4'b1110, ~7'h7F})
                    $display("FAIL midframe_new got an=%b seg=%h want an=1110 seg=00", an, seg);
                else n_pass++;
            end
            n_checks++;
            if ({seg, dp, an, frame_start} !== {exp_seg, exp_dp, exp_an, exp_fs})
                $display("FAIL midframe cyc=%0d got seg=%h dp=%b an=%b fs=%b want seg=%h dp=%b an=%b fs=%b",
                         i, seg, dp, an, frame_start, exp_seg, exp_dp, exp_an, exp_fs);
            else n_pass++;
        end
    endtask

    task automatic test_invalid_dp();
        digits_in = 16'h00A0; dp_in = 4'b0100;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i >= 20 && an == 4'b1101) begin
                n_checks++;
                if (seg !== 7'h7F) $display("FAIL invalid_code got seg=%h want=7f", seg); else n_pass++;
            end
            if (i >= 20) begin
                n_checks++;
                if (dp !== ((an == 4'b1011) ? 1'b0 : 1'b1))
                    $display("FAIL dp_select got dp=%b an=%b", dp, an);
                else n_pass++;
            end
            n_checks++;
            if ({seg, dp, an, frame_start} !== {exp_seg, exp_dp, exp_an, exp_fs})
                $display("FAIL invalid_dp cyc=%0d got seg=%h dp=%b an=%b fs=%b want seg=%h dp=%b an=%b fs=%b",
                         i, seg, dp, an, frame_start, exp_seg, exp_dp, exp_an, exp_fs);
            else n_pass++;
        end
    endtask

    task automatic test_en_pause();
        int budget = 40;
        digits_in = 16'h1234; dp_in = 4'b0000;
        while (an !== 4'b1011 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        n_checks++;
        if (budget == 0) $display("FAIL pause_wait got an=%b want an=1011 within 40 cycles", an);
        else n_pass++;
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_checks++;
            if ({an, seg, dp, frame_start} !== {4'hF, 7'h7F, 1'b1, 1'b0})
                $display("FAIL pause_blank cyc=%0d got an=%b seg=%h dp=%b fs=%b want an=1111 seg=7f dp=1 fs=0",
                         i, an, seg, dp, frame_start);
            else n_pass++;
        end
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if (an !== ((i < 3) ? 4'b1011 : 4'b0111))
                $display("FAIL pause_resume cyc=%0d got an=%b want=%b", i, an, (i < 3) ? 4'b1011 : 4'b0111);
            else n_pass++;
        end
    endtask

    task automatic test_blank();
        logic [6:0] want;
        digits_in = 16'h0007;
        for (int i = 0; i < 64; i++) begin
            if (i == 32) digits_in = 16'h0000;
            @(negedge clk);
            if ((i >= 20 && i < 32) || i >= 52) begin
                if (an == 4'b1110) begin
                    want = (i < 32) ? 7'h78 : 7'h40;
                    n_checks++;
                    if (seg !== want) $display("FAIL blank_digit0 got seg=%h want=%h", seg, want); else n_pass++;
                end
                if (an == 4'b0111) begin
`ifdef SEG7_LEADING_ZERO_BLANK_EN
                    want = 7'h7F;
`else
                    want = 7'h40;
`endif
                    n_checks++;
                    if (seg !== want) $display("FAIL blank_digit3 got seg=%h want=%h", seg, want); else n_pass++;
                end
            end
            n_checks++;
            if ({seg, dp, an, frame_start} !== {exp_seg, exp_dp, exp_an, exp_fs})
                $display("FAIL blank cyc=%0d got seg=%h dp=%b an=%b fs=%b want seg=%h dp=%b an=%b fs=%b",
                         i, seg, dp, an, frame_start, exp_seg, exp_dp, exp_an, exp_fs);
            else n_pass++;
        end
    endtask

    task automatic test_rst_mid();
        digits_in = 16'h4321;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({an, seg, dp, frame_start} !== {4'hF, 7'h7F, 1'b1, 1'b0})
            $display("FAIL rst_mid got an=%b seg=%h dp=%b fs=%b want an=1111 seg=7f dp=1 fs=0",
                     an, seg, dp, frame_start);
        else n_pass++;
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({an, seg, frame_start} !== {4'b1110, ~7'h06, 1'b1})
            $display("FAIL rst_restart got an=%b seg=%h fs=%b want an=1110 seg=79 fs=1", an, seg, frame_start);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 9) == 0) digits_in = 16'($urandom);
            if ($urandom_range(0, 9) == 0) dp_in = 4'($urandom);
            if ($urandom_range(0, 7) == 0) en = ~en;
            rst = ($urandom_range(0, 99) == 0);
            @(negedge clk);
            n_checks++;
            if ({seg, dp, an, frame_start} !== {exp_seg, exp_dp, exp_an, exp_fs})
                $display("FAIL random cyc=%0d got seg=%h dp=%b an=%b fs=%b want seg=%h dp=%b an=%b fs=%b",
                         i, seg, dp, an, frame_start, exp_seg, exp_dp, exp_an, exp_fs);
            else n_pass++;
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_scan_1234();
        test_midframe_change();
        test_invalid_dp();
        test_en_pause();
        test_blank();
        test_rst_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
